// File: rtl/rdm_combine_sink.sv
// rdm_combine_sink: requests E01 RDM words and soft-combines each one into the circular HARQ buffer.
// Optional lane saturation is enabled by defining RDM_COMBINE_SAT_EN (default build wraps).

module rdm_combine_sink #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LLR_WIDTH       = 8
) (
  input  logic         i_core_clk,
  input  logic         i_rx_rst,
  input  logic         i_Combine_start,
  input  logic [13:0]  i_Current_Combine_E01_Size,
  input  logic [15:0]  i_Current_Combine_Ncb_Size,
  input  logic [15:0]  i_Combine_Start_Offset,
  output logic         o_Combine_process_request,
  output logic         o_RDM_Data_Request,
  input  logic         i_RDM_Data_Valid,
  input  logic         i_RDM_Data_Comp,
  input  logic [95:0]  i_RDM_Data_Content,
  output logic         o_Combine_Buffer_Rd_En,
  output logic [15:0]  o_Combine_Buffer_Rd_Addr,
  input  logic [95:0]  i_Combine_Buffer_Rd_Data,
  output logic         o_Combine_Buffer_Wr_En,
  output logic [15:0]  o_Combine_Buffer_Wr_Addr,
  output logic [95:0]  o_Combine_Buffer_Wr_Data,
  output logic         o_Combine_busy,
  output logic         o_Combine_done,
  output logic         o_Combine_err
);

  localparam int W     = LLR_WIDTH;
  localparam int LANES = 96 / LLR_WIDTH;
  localparam logic [13:0] MAX_OUT = 14'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  state_t       state_nx;

  logic [13:0]  e01_q;
  logic [15:0]  ncb_q;
  logic [15:0]  wr_ptr;
  logic [13:0]  req_cnt;
  logic [13:0]  rcv_cnt;
  logic         err_q;
  logic         preq_q;
  logic         done_q;

  logic         s1_valid;
  logic [15:0]  s1_addr;
  logic [95:0]  s1_word;
  logic         fwd_valid;
  logic [95:0]  fwd_data;

  logic [13:0]  outstanding;
  logic         start_ok;
  logic         cfg_bad;
  logic         req_fire;
  logic         vld_busy;
  logic         accept;
  logic         last_word;
  logic         comp_err;
  logic         drop_err;
  logic [15:0]  wr_ptr_nx;
  logic [95:0]  rd_eff;
  logic [95:0]  comb_word;

  // Handshake: each o_RDM_Data_Request pulse grants the source exactly one i_RDM_Data_Valid
  // beat in a later cycle; a valid arriving without an open grant is dropped and flagged.
  assign outstanding = req_cnt - rcv_cnt;
  assign start_ok    = (state == IDLE) && i_Combine_start;
  assign cfg_bad     = (i_Current_Combine_Ncb_Size == 16'd0) ||
                       (i_Combine_Start_Offset >= i_Current_Combine_Ncb_Size);
  assign req_fire    = (state == REQ) && (req_cnt < e01_q) && (outstanding < MAX_OUT);
  assign vld_busy    = i_RDM_Data_Valid && (state != IDLE);
  assign accept      = vld_busy && (rcv_cnt < e01_q) && (outstanding != 14'd0);
  assign drop_err    = vld_busy && !accept;
  assign last_word   = ((rcv_cnt + 14'd1) == e01_q);
  assign comp_err    = accept && (i_RDM_Data_Comp != last_word);
  assign wr_ptr_nx   = (({1'b0, wr_ptr} + 17'd1) == {1'b0, ncb_q}) ? 16'd0 : wr_ptr + 16'd1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_Combine_start) begin
          if (i_Current_Combine_E01_Size == 14'd0) state_nx = DONE;
          else if (cfg_bad)                        state_nx = DONE;
          else                                     state_nx = REQ;
        end
      end
      REQ: begin
        if (req_cnt == e01_q) state_nx = DRAIN;
      end
      DRAIN: begin
        if ((rcv_cnt == e01_q) && !s1_valid) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state     <= IDLE;
      e01_q     <= '0;
      ncb_q     <= '0;
      wr_ptr    <= '0;
      req_cnt   <= '0;
      rcv_cnt   <= '0;
      err_q     <= 1'b0;
      preq_q    <= 1'b0;
      done_q    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_word   <= '0;
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
    end else begin
      state     <= state_nx;
      preq_q    <= start_ok;
      done_q    <= (state == DONE);
      s1_valid  <= accept;
      // Ncb==1 back-to-back: the RAM returns the pre-write word, so carry the fresh sum forward.
      fwd_valid <= accept && s1_valid && (wr_ptr == s1_addr);
      fwd_data  <= comb_word;
      if (accept) begin
        s1_addr <= wr_ptr;
        s1_word <= i_RDM_Data_Content;
      end
      if (start_ok) begin
        e01_q   <= i_Current_Combine_E01_Size;
        ncb_q   <= i_Current_Combine_Ncb_Size;
        wr_ptr  <= i_Combine_Start_Offset;
        req_cnt <= '0;
        rcv_cnt <= '0;
        err_q   <= (i_Current_Combine_E01_Size != 14'd0) && cfg_bad;
      end else begin
        if (req_fire) req_cnt <= req_cnt + 14'd1;
        if (accept) begin
          rcv_cnt <= rcv_cnt + 14'd1;
          wr_ptr  <= wr_ptr_nx;
        end
        if (drop_err || comp_err) err_q <= 1'b1;
      end
    end
  end

  assign rd_eff = fwd_valid ? fwd_data : i_Combine_Buffer_Rd_Data;

`ifdef RDM_COMBINE_SAT_EN
  localparam logic [W-1:0] LANE_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] LANE_MIN = {1'b1, {(W-1){1'b0}}};
  logic [W:0] lane_sum;

  always_comb begin
    comb_word = '0;
    lane_sum  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = {rd_eff[i*W+W-1], rd_eff[i*W +: W]} + {s1_word[i*W+W-1], s1_word[i*W +: W]};
      // Sign bits disagree only on overflow; the extra bit gives the true sign.
      if (lane_sum[W] != lane_sum[W-1])
        comb_word[i*W +: W] = lane_sum[W] ? LANE_MIN : LANE_MAX;
      else
        comb_word[i*W +: W] = lane_sum[W-1:0];
    end
  end
`else
  always_comb begin
    comb_word = '0;
    for (int i = 0; i < LANES; i++) begin
      comb_word[i*W +: W] = rd_eff[i*W +: W] + s1_word[i*W +: W];
    end
  end
`endif

  assign o_Combine_process_request = preq_q;
  assign o_RDM_Data_Request        = req_fire;
  assign o_Combine_Buffer_Rd_En    = accept;
  assign o_Combine_Buffer_Rd_Addr  = accept ? wr_ptr : 16'd0;
  assign o_Combine_Buffer_Wr_En    = s1_valid;
  assign o_Combine_Buffer_Wr_Addr  = s1_valid ? s1_addr : 16'd0;
  assign o_Combine_Buffer_Wr_Data  = s1_valid ? comb_word : 96'd0;
  assign o_Combine_busy            = (state != IDLE);
  assign o_Combine_done            = done_q;
  assign o_Combine_err             = err_q;

endmodule

// File: tb/tb_rdm_combine_sink.sv
// Bench for rdm_combine_sink: delayed-answer RDM source, buffer RAM model and write scoreboard.

module tb_rdm_combine_sink;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [13:0]  e01;
  logic [15:0]  ncb;
  logic [15:0]  off;
  logic         preq;
  logic         req;
  logic         valid;
  logic         comp;
  logic [95:0]  content;
  logic         rd_en;
  logic [15:0]  rd_addr;
  logic [95:0]  rd_data;
  logic         wr_en;
  logic [15:0]  wr_addr;
  logic [95:0]  wr_data;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  rdm_combine_sink #(.MAX_OUTSTANDING(4), .LLR_WIDTH(8)) dut (
    .i_core_clk                 (clk),
    .i_rx_rst                   (rst),
    .i_Combine_start            (start),
    .i_Current_Combine_E01_Size (e01),
    .i_Current_Combine_Ncb_Size (ncb),
    .i_Combine_Start_Offset     (off),
    .o_Combine_process_request  (preq),
    .o_RDM_Data_Request         (req),
    .i_RDM_Data_Valid           (valid),
    .i_RDM_Data_Comp            (comp),
    .i_RDM_Data_Content         (content),
    .o_Combine_Buffer_Rd_En     (rd_en),
    .o_Combine_Buffer_Rd_Addr   (rd_addr),
    .i_Combine_Buffer_Rd_Data   (rd_data),
    .o_Combine_Buffer_Wr_En     (wr_en),
    .o_Combine_Buffer_Wr_Addr   (wr_addr),
    .o_Combine_Buffer_Wr_Data   (wr_data),
    .o_Combine_busy             (busy),
    .o_Combine_done             (done),
    .o_Combine_err              (err)
  );

  // Buffer RAM: registered read of the pre-write contents.
  logic [95:0] mem [0:15];
  logic        fill_req = 1'b0;
  logic [95:0] fill_val = '0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= fill_val;
    end else if (wr_en) begin
      mem[wr_addr[3:0]] <= wr_data;
    end
    if (rd_en) rd_data <= mem[rd_addr[3:0]];
  end

  // Scoreboard and reference state.
  logic [15:0] exp_addr_q[$];
  logic [95:0] exp_q[$];
  logic [95:0] exp_mem [0:15];
  logic [95:0] words [0:15];
  int          pend_q[$];
  int m_ptr, m_ncb, n_sent, comp_idx, src_delay;
  logic src_on = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int n_req = 0, n_rd = 0, n_wr = 0, n_done = 0, n_preq = 0;
  int preq_cyc = -1, done_cyc = -1, start_cyc = -10;
  int tb_out = 0, max_out = 0;
  logic err_after_start = 1'b0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] ref_comb(input logic [95:0] a, input logic [95:0] b);
    logic [95:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      s = int'($signed(a[i*8 +: 8])) + int'($signed(b[i*8 +: 8]));
`ifdef RDM_COMBINE_SAT_EN
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
`endif
      r[i*8 +: 8] = 8'(s);
    end
    return r;
  endfunction

  function automatic logic outs_any();
    return preq | req | rd_en | (|rd_addr) | wr_en | (|wr_addr) | (|wr_data) | busy | done | err;
  endfunction

  // Monitor: samples on the falling edge, counts events and checks writes against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (req) begin
        n_req++;
        pend_q.push_back(cyc + src_delay);
        tb_out++;
      end
      if (valid) tb_out--;
      if (tb_out > max_out) max_out = tb_out;
      if (rd_en) n_rd++;
      if (wr_en) begin
        n_wr++;
        check("wr_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("wr_addr", wr_addr, exp_addr_q.pop_front());
          check("wr_data", wr_data, exp_q.pop_front());
        end
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (preq) begin n_preq++; preq_cyc = cyc; end
      if (cyc == start_cyc + 1) err_after_start = err;
      cyc++;
    end
  end

  // Source: answers each request src_delay cycles later, pushing the expected write.
  initial begin
    logic [95:0] d;
    valid   = 1'b0;
    comp    = 1'b0;
    content = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !src_on) begin
        valid = 1'b0;
        comp  = 1'b0;
      end else if (pend_q.size() > 0 && pend_q[0] <= cyc) begin
        void'(pend_q.pop_front());
        valid   = 1'b1;
        content = words[n_sent];
        comp    = (n_sent + 1 == comp_idx);
        d = ref_comb(exp_mem[m_ptr], words[n_sent]);
        exp_mem[m_ptr] = d;
        exp_addr_q.push_back(16'(m_ptr));
        exp_q.push_back(d);
        m_ptr = (m_ptr + 1 == m_ncb) ? 0 : m_ptr + 1;
        n_sent++;
      end else begin
        valid = 1'b0;
        comp  = 1'b0;
      end
    end
  end

  task automatic start_job(input int je01, input int jncb, input int joff, input int jdelay,
                           input int jcomp, input logic [95:0] jfill);
    @(posedge clk); #1;
    fill_val = jfill;
    fill_req = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = jfill;
    @(posedge clk); #1;
    fill_req  = 1'b0;
    m_ptr     = joff;
    m_ncb     = jncb;
    n_sent    = 0;
    comp_idx  = jcomp;
    src_delay = jdelay;
    max_out   = 0;
    src_on    = 1'b1;
    e01       = 14'(je01);
    ncb       = 16'(jncb);
    off       = 16'(joff);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    for (int k = 0; k < 2000 && n_done == base; k++) @(posedge clk);
    check({tag, "_done_seen"}, (n_done > base), 1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_once"}, n_done - base, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int b_done, b_req, b_rd, b_wr;
    rst   = 1'b1;
    start = 1'b0;
    e01   = '0;
    ncb   = '0;
    off   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs_any(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", outs_any(), 0);

    // 1: wrap across Ncb with zero buffer
    for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom, $urandom};
    b_done = n_done; b_req = n_req; b_wr = n_wr;
    start_job(5, 8, 6, 3, 5, 96'd0);
    wait_done("t1", b_done);
    check("t1_err", err, 0);
    check("t1_req_count", n_req - b_req, 5);
    check("t1_wr_count", n_wr - b_wr, 5);
    check("t1_max_outstanding_ok", (max_out <= 4), 1);
    check("t1_mem0", mem[0], words[2]);

    // 2: empty job
    b_done = n_done; b_req = n_req; b_rd = n_rd; b_wr = n_wr;
    start_job(0, 8, 0, 3, 0, 96'd0);
    wait_done("t2", b_done);
    check("t2_preq_cycle", preq_cyc - start_cyc, 1);
    check("t2_done_cycle", done_cyc - start_cyc, 2);
    check("t2_no_req", n_req - b_req, 0);
    check("t2_no_rd", n_rd - b_rd, 0);
    check("t2_no_wr", n_wr - b_wr, 0);
    check("t2_err", err, 0);

    // 3: Ncb=1 back-to-back accumulation
    for (int i = 0; i < 16; i++) words[i] = {12{8'h10}};
    b_done = n_done;
    start_job(3, 1, 0, 1, 3, 96'd0);
    wait_done("t3", b_done);
    check("t3_accum", mem[0], {12{8'h30}});
    check("t3_err", err, 0);

    // 4: lane overflow behaviour
    for (int i = 0; i < 16; i++) words[i] = {12{8'h20}};
    b_done = n_done;
    start_job(1, 4, 2, 2, 1, {12{8'h70}});
    wait_done("t4a", b_done);
`ifdef RDM_COMBINE_SAT_EN
    check("t4_pos_overflow", mem[2][7:0], 8'h7F);
`else
    check("t4_pos_overflow", mem[2][7:0], 8'h90);
`endif
    for (int i = 0; i < 16; i++) words[i] = {12{8'hF0}};
    b_done = n_done;
    start_job(1, 4, 2, 2, 1, {12{8'h90}});
    wait_done("t4b", b_done);
    check("t4_neg_overflow", mem[2][7:0], 8'h80);

    // 5: early comp flags a sticky error; next start clears it
    for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom, $urandom};
    b_done = n_done; b_wr = n_wr;
    start_job(4, 8, 0, 2, 2, 96'd0);
    wait_done("t5", b_done);
    check("t5_err_set", err, 1);
    check("t5_wr_count", n_wr - b_wr, 4);
    repeat (5) @(posedge clk);
    #1;
    check("t5_err_sticky", err, 1);
    b_done = n_done;
    start_job(3, 8, 5, 2, 3, 96'd0);
    wait_done("t5b", b_done);
    check("t5b_err_cleared_at_start", err_after_start, 0);
    check("t5b_err", err, 0);

    // 6: reset in the cycle after the second write
    for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom, $urandom};
    b_done = n_done; b_wr = n_wr;
    start_job(10, 16, 3, 2, 10, 96'd0);
    for (int k = 0; k < 200 && (n_wr - b_wr) < 2; k++) @(posedge clk);
    check("t6_two_writes", ((n_wr - b_wr) >= 2), 1);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    src_on = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    pend_q.delete();
    tb_out = 0;
    @(negedge clk);
    check("t6_outputs_zero", outs_any(), 0);
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_done", n_done - b_done, 0);
    b_done = n_done; b_wr = n_wr;
    start_job(6, 16, 14, 3, 6, 96'd0);
    wait_done("t6b", b_done);
    check("t6b_err", err, 0);
    check("t6b_wr_count", n_wr - b_wr, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rdm_combine_sink.md
Name: rdm_combine_sink

Overview:
- Consumer end of the RDM data interface: sends the combine-process request, pulls E01 96-bit RDM words through the request/valid/comp handshake, and soft-combines each word into the HARQ combine buffer.
- Combining is a read-modify-write per word at a circular address modulo Ncb, starting at a given word offset.
- Sits between the RDM reader FSM and the combine buffer RAM, in the i_core_clk domain.

Parameters:
MAX_OUTSTANDING, 4, maximum number of issued but unanswered o_RDM_Data_Request pulses (1..15)
LLR_WIDTH, 8, signed soft-bit width; 96/LLR_WIDTH lanes per word (LLR_WIDTH must divide 96)

Ports:
i_core_clk  in  1  core clock, all logic on rising edge
i_rx_rst  in  1  synchronous active-high reset
i_Combine_start  in  1  one-cycle start pulse; sizes/offset sampled on this cycle
i_Current_Combine_E01_Size  in  14  number of RDM words to combine
i_Current_Combine_Ncb_Size  in  16  circular buffer length in words
i_Combine_Start_Offset  in  16  first write word address (must be < Ncb)
o_Combine_process_request  out  1  one-cycle pulse to the RDM reader at job start
o_RDM_Data_Request  out  1  one-cycle pulse per requested word
i_RDM_Data_Valid  in  1  RDM word valid
i_RDM_Data_Comp  in  1  asserted with the last valid word of the job
i_RDM_Data_Content  in  96  RDM word
o_Combine_Buffer_Rd_En  out  1  buffer read strobe
o_Combine_Buffer_Rd_Addr  out  16  buffer read address
i_Combine_Buffer_Rd_Data  in  96  read data, valid exactly 1 cycle after Rd_En
o_Combine_Buffer_Wr_En  out  1  buffer write strobe
o_Combine_Buffer_Wr_Addr  out  16  buffer write address
o_Combine_Buffer_Wr_Data  out  96  combined word
o_Combine_busy  out  1  high from accepted start until DONE exits
o_Combine_done  out  1  one-cycle completion pulse
o_Combine_err  out  1  sticky error, cleared by the next accepted start or by reset

Behaviour:
- Reset: all outputs 0. Address regs and counters 0. State IDLE.
- The interface is decided: single clock i_core_clk; reset i_rx_rst is synchronous and active-high.
- States: IDLE, REQ, DRAIN, DONE.
- IDLE: on i_Combine_start, latch E01, Ncb and offset; pulse o_Combine_process_request; set busy; clear err.
  - If E01==0: go to DONE.
  - If Ncb==0 or offset>=Ncb: set err and go to DONE.
  - Otherwise go to REQ.
  - A start pulse while busy is ignored.
- REQ: pulse o_RDM_Data_Request on every cycle where req_cnt<E01 and outstanding<MAX_OUTSTANDING.
  - outstanding = req_cnt - rcv_cnt. A request and a valid in the same cycle leave outstanding unchanged.
  - When req_cnt==E01, go to DRAIN.
- DRAIN: wait until rcv_cnt==E01 and the RMW pipeline is empty, then go to DONE.
- DONE: pulse o_Combine_done for one cycle, clear busy, return to IDLE.
- Receive (any state except IDLE):
  - On i_RDM_Data_Valid with rcv_cnt<E01: Rd_En=1 and Rd_Addr=wr_ptr in the same cycle. Register the RDM word and address. Increment rcv_cnt.
  - Advance wr_ptr = (wr_ptr+1==Ncb) ? 0 : wr_ptr+1.
- Combine stage, one cycle later:
  - Per lane, Wr_Data = combine(buffer lane, RDM lane). Wr_En=1, Wr_Addr=registered address.
  - Latency from valid to write: 1 cycle.
- Hazard: if this cycle's read address equals the address being written this cycle (Ncb==1 case), the read data is the write data. The back-to-back accumulation must be correct.
- Comp checks:
  - i_RDM_Data_Comp on a word other than word E01 sets err.
  - No comp on word E01 sets err.
  - Processing still completes after E01 words.
- A valid while outstanding==0, or while in IDLE, is dropped and sets err (in IDLE it is dropped only).
- Reset mid-job aborts immediately: no done pulse, outputs 0.

Optional Feature:
Macro RDM_COMBINE_SAT_EN.
- Defined: the lane sum saturates to [-2^(LLR_WIDTH-1), 2^(LLR_WIDTH-1)-1].
- Undefined: the lane sum is a two's-complement wraparound add truncated to LLR_WIDTH.

Test Plan:
1. Ncb=8, offset=6, E01=5, buffer all zero, source answers every request 3 cycles later, comp on word 5 -> writes at addresses 6,7,0,1,2 with RDM data unchanged; done pulses once; err=0; outstanding never exceeds 4.
2. E01=0 -> process_request pulse, then done 2 cycles after start; no RDM request, read or write; err=0.
3. Ncb=1, E01=3, every lane 0x10 on each word, valid back-to-back -> final address 0 lane value 0x30, confirming forwarding.
4. With RDM_COMBINE_SAT_EN, buffer lane 0x70 + RDM lane 0x20 -> 0x7F; without the macro -> 0x90. Lane 0x90 + 0xF0 -> 0x80 saturated, 0x80 wrapped.
5. E01=4, comp asserted on word 2 -> err=1 and stays set; all 4 words written; done pulses. The next start clears err.
6. i_rx_rst asserted in the cycle after the second write of an E01=10 job -> all outputs 0 the next cycle; no done pulse; a new start runs cleanly.
